instr_encoder_loader: RTL and testbench

//  Producer-side counterpart of the IF/ID decode: packs instruction fields into the 48-bit instruction word

---
 rtl/instr_encoder_loader_if.sv | 35 +++
 rtl/instr_encoder_loader.sv | 157 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Field-tuple stream between the host/testbench loader and the instruction encoder.
// The host drives one instruction's fields per beat and the loader accepts a beat when
// in_valid and in_ready are both high on a rising clock edge.
//
// Signals:
//   in_valid   host -> loader   tuple valid
//   in_ready   loader -> host   loader can accept a tuple
//   in_opcode  host -> loader   6-bit opcode
//   in_rd      host -> loader   destination register
//   in_rs      host -> loader   source register
//   in_rt      host -> loader   second source (register-format ops)
//   in_imm     host -> loader   immediate / jump or branch target
//   in_last    host -> loader   final tuple of the session
//
// Modports: master = host side, slave = loader side.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [31:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs, in_rt, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / imem loader.
// Packs instruction field tuples into the 48-bit instruction word that the pipeline
// decodes, rejects unknown opcodes, and streams the words into instruction memory
// starting at a session base address. One word per cycle, one cycle of latency from
// accept to imem write.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start, base_addr  begin a load session at base_addr (ignored while loading)
//   tuple             field-tuple stream (slave side of instr_encoder_loader_if)
//   imem_we/addr/wdata imem write port, one strobe per encoded word
//   count             words written this session
//   busy              session in progress
//   done / err        sticky session outcome, cleared by the next start
//   err_code          01 illegal opcode, 10 imem overflow, 00 none
//   err_opcode        offending opcode for an illegal-opcode abort
//   checksum          XOR of all words written this session
//
// Build option: define LOADER_CHECKSUM_EN to build the checksum register; without it
// checksum is tied to zero.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  instr_encoder_loader_if.slave tuple,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [47:0]          imem_wdata,
  output logic [ADDR_W:0]      count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [5:0]           err_opcode,
  output logic [47:0]          checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic                legal;
  logic [4:0]          enc_rd;
  logic [4:0]          enc_rs;
  logic [31:0]         enc_low;
  logic [47:0]         enc_word;
  logic                accept;

  // Opcode classification and low-field packing. J and NOP force the register
  // fields to zero so the decoder sees canonical words regardless of host input.
  always_comb begin
    legal   = 1'b1;
    enc_rd  = tuple.in_rd;
    enc_rs  = tuple.in_rs;
    enc_low = 32'h0;
    case (tuple.in_opcode)
      6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16:
        enc_low = {tuple.in_rt, 27'h0};
      6'h0B, 6'h22, 6'h23, 6'h24, 6'h25:
        enc_low = tuple.in_imm;
      6'h20: begin
        enc_rd  = 5'h0;
        enc_rs  = 5'h0;
        enc_low = tuple.in_imm;
      end
      6'h21: begin
        enc_rd = 5'h0;
        enc_rs = 5'h0;
      end
      default: legal = 1'b0;
    endcase
  end

  assign enc_word       = {tuple.in_opcode, enc_rd, enc_rs, enc_low};
  assign tuple.in_ready = (state == LOAD);
  assign busy           = (state == LOAD);
  assign accept         = tuple.in_valid & tuple.in_ready;

  // Session FSM. The write pointer saturates at all-ones: a non-final word written
  // there ends the session with an overflow error instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 48'h0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      err_opcode <= 6'h0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LOAD;
            ptr      <= base_addr;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
          end
        end
        LOAD: begin
          if (accept) begin
            if (!legal) begin
              state      <= ERR;
              err        <= 1'b1;
              err_code   <= 2'b01;
              err_opcode <= tuple.in_opcode;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc_word;
              count      <= count + (ADDR_W+1)'(1);
              if (tuple.in_last) begin
                state <= DONE;
                done  <= 1'b1;
              end else if (&ptr) begin
                state    <= ERR;
                err      <= 1'b1;
                err_code <= 2'b10;
              end else begin
                ptr <= ptr + ADDR_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [47:0] checksum_q;

  // Running XOR of written words; a session start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= 48'h0;
    end else if (start && state != LOAD) begin
      checksum_q <= 48'h0;
    end else if (imem_we) begin
      checksum_q <= checksum_q ^ imem_wdata;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 48'h0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader: reset values, field encoding per class,
// back-to-back streaming, illegal opcode, overflow at the top of imem, start-while-busy,
// checksum, and reset during an in-flight write.
module tb_instr_encoder_loader;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [47:0] imem_wdata;
  logic [8:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [5:0]  err_opcode;
  logic [47:0] checksum;

  int checks;
  int errors;

  instr_encoder_loader_if tuple_if ();

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .tuple      (tuple_if),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .err_opcode (err_opcode),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic drive_tuple(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [31:0] imm, input logic last);
    tuple_if.in_valid  = 1'b1;
    tuple_if.in_opcode = op;
    tuple_if.in_rd     = rd;
    tuple_if.in_rs     = rs;
    tuple_if.in_rt     = rt;
    tuple_if.in_imm    = imm;
    tuple_if.in_last   = last;
  endtask

  task automatic send_tuple(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [31:0] imm, input logic last);
    drive_tuple(op, rd, rs, rt, imm, last);
    tick();
    tuple_if.in_valid = 1'b0;
  endtask

  // Back-to-back stream: J (rd/rs forced to 0), NOP, BEQ, SRL with last.
  logic [5:0]  b2b_op   [4] = '{6'h20, 6'h21, 6'h23, 6'h11};
  logic [4:0]  b2b_rd   [4] = '{5'd5, 5'd1, 5'd1, 5'd31};
  logic [4:0]  b2b_rs   [4] = '{5'd6, 5'd1, 5'd2, 5'd31};
  logic [4:0]  b2b_rt   [4] = '{5'd0, 5'd1, 5'd0, 5'd31};
  logic [31:0] b2b_imm  [4] = '{32'h0000_0040, 32'h0000_FFFF, 32'h1234_5678, 32'h0};
  logic [47:0] b2b_word [4] = '{48'h8000_0000_0040, 48'h8400_0000_0000,
                                48'h8C22_1234_5678, 48'h47FF_F800_0000};

  initial begin
    logic [47:0] exp_cks;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 8'h0;
    tuple_if.in_valid = 1'b0;
    tuple_if.in_opcode = 6'h0;
    tuple_if.in_rd = 5'h0;
    tuple_if.in_rs = 5'h0;
    tuple_if.in_rt = 5'h0;
    tuple_if.in_imm = 32'h0;
    tuple_if.in_last = 1'b0;

    #2;
    check_output("rst_in_ready", 64'(tuple_if.in_ready), 64'h0);
    check_output("rst_we", 64'(imem_we), 64'h0);
    check_output("rst_busy_done_err", 64'({busy, done, err}), 64'h0);
    check_output("rst_addr", 64'(imem_addr), 64'h0);
    check_output("rst_wdata", 64'(imem_wdata), 64'h0);
    check_output("rst_count", 64'(count), 64'h0);
    check_output("rst_err_code", 64'({err_code, err_opcode}), 64'h0);
    check_output("rst_checksum", 64'(checksum), 64'h0);
    #20;
    rst_n = 1'b1;
    tick();

    $display("[TB] single ADDI session at 0x10");
    pulse_start(8'h10);
    check_output("start_busy", 64'({busy, tuple_if.in_ready}), 64'h3);
    send_tuple(6'h0B, 5'd3, 5'd1, 5'd0, 32'h0000_0005, 1'b1);
    check_output("addi_we", 64'(imem_we), 64'h1);
    check_output("addi_addr", 64'(imem_addr), 64'h10);
    check_output("addi_wdata", 64'(imem_wdata), 64'h2C61_0000_0005);
    check_output("addi_done", 64'({done, err, busy}), 64'h4);
    check_output("addi_count", 64'(count), 64'h1);
    tick();
    check_output("idle_we_low", 64'(imem_we), 64'h0);
    check_output("idle_addr_hold", 64'(imem_addr), 64'h10);

    $display("[TB] XOR then four back-to-back tuples at 0x20");
    pulse_start(8'h20);
    check_output("restart_done_clr", 64'(done), 64'h0);
    send_tuple(6'h10, 5'd2, 5'd4, 5'd7, 32'hFFFF_FFFF, 1'b0);
    check_output("xor_wdata", 64'(imem_wdata), 64'h4044_3800_0000);
    check_output("xor_addr", 64'(imem_addr), 64'h20);
    for (int i = 0; i < 4; i++) begin
      drive_tuple(b2b_op[i], b2b_rd[i], b2b_rs[i], b2b_rt[i], b2b_imm[i], i == 3);
      tick();
      check_output($sformatf("b2b_we_%0d", i), 64'(imem_we), 64'h1);
      check_output($sformatf("b2b_addr_%0d", i), 64'(imem_addr), 64'(8'h21 + 8'(i)));
      check_output($sformatf("b2b_wdata_%0d", i), 64'(imem_wdata), 64'(b2b_word[i]));
    end
    tuple_if.in_valid = 1'b0;
    check_output("b2b_count", 64'(count), 64'h5);
    check_output("b2b_done", 64'({done, err}), 64'h2);

    $display("[TB] checksum session: NOP then J");
    pulse_start(8'h60);
    send_tuple(6'h21, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    send_tuple(6'h20, 5'd0, 5'd0, 5'd0, 32'h0000_0040, 1'b1);
    tick();
`ifdef LOADER_CHECKSUM_EN
    exp_cks = 48'h0400_0000_0040;
`else
    exp_cks = 48'h0;
`endif
    check_output("checksum", 64'(checksum), 64'(exp_cks));

    $display("[TB] illegal opcode 0x3F");
    pulse_start(8'h30);
    send_tuple(6'h3F, 5'd1, 5'd1, 5'd1, 32'h1, 1'b0);
    check_output("ill_we", 64'(imem_we), 64'h0);
    check_output("ill_err", 64'({err, done, tuple_if.in_ready}), 64'h4);
    check_output("ill_code", 64'(err_code), 64'h1);
    check_output("ill_opcode", 64'(err_opcode), 64'h3F);
    check_output("ill_count", 64'(count), 64'h0);

    $display("[TB] illegal opcode 0x17 with last");
    pulse_start(8'h30);
    check_output("restart_err_clr", 64'({err, err_code}), 64'h0);
    send_tuple(6'h17, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
    check_output("ill_last", 64'({err, done, err_code}), 64'h9);
    check_output("ill_last_opc", 64'(err_opcode), 64'h17);

    $display("[TB] overflow from base 0xFE");
    pulse_start(8'hFE);
    drive_tuple(6'h0B, 5'd1, 5'd0, 5'd0, 32'h1, 1'b0);
    tick();
    check_output("ovf_addr0", 64'({imem_we, imem_addr}), 64'h1FE);
    drive_tuple(6'h0B, 5'd1, 5'd0, 5'd0, 32'h2, 1'b0);
    tick();
    check_output("ovf_addr1", 64'({imem_we, imem_addr}), 64'h1FF);
    check_output("ovf_err", 64'({err, err_code, tuple_if.in_ready}), 64'hC);
    drive_tuple(6'h0B, 5'd1, 5'd0, 5'd0, 32'h3, 1'b0);
    tick();
    tuple_if.in_valid = 1'b0;
    check_output("ovf_no_third", 64'({imem_we, imem_addr}), 64'h0FF);
    check_output("ovf_count", 64'(count), 64'h2);

    $display("[TB] last word at 0xFF completes normally");
    pulse_start(8'hFF);
    send_tuple(6'h24, 5'd2, 5'd3, 5'd0, 32'hDEAD_BEEF, 1'b1);
    check_output("top_last_addr", 64'({imem_we, imem_addr}), 64'h1FF);
    check_output("top_last_done", 64'({done, err, err_code}), 64'h8);
    check_output("top_last_wdata", 64'(imem_wdata), 64'h9043_DEAD_BEEF);

    $display("[TB] start while loading is ignored");
    pulse_start(8'h40);
    pulse_start(8'h50);
    send_tuple(6'h25, 5'd1, 5'd1, 5'd0, 32'h0, 1'b1);
    check_output("start_ignored", 64'(imem_addr), 64'h40);

    $display("[TB] reset with a write in flight");
    pulse_start(8'h70);
    send_tuple(6'h0B, 5'd1, 5'd1, 5'd0, 32'h7, 1'b0);
    check_output("pre_rst_we", 64'(imem_we), 64'h1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_we", 64'(imem_we), 64'h0);
    check_output("mid_rst_state", 64'({busy, tuple_if.in_ready, done, err}), 64'h0);
    check_output("mid_rst_addr_count", 64'({imem_addr, count}), 64'h0);
    #3;
    rst_n = 1'b1;
    tick();
    check_output("post_rst_idle", 64'({busy, imem_we}), 64'h0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
